// File: rtl/gato_pkg.sv
// Shared encodings for the N x N gato controller: cell values, FSM state codes,
// line directions and the per-direction (drow, dcol) step table.
package gato_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  typedef enum logic [2:0] {
    ST_P1_TURN = 3'd0,
    ST_P2_TURN = 3'd1,
    ST_CHECK   = 3'd2,
    ST_WIN1    = 3'd3,
    ST_WIN2    = 3'd4,
    ST_TIE     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    DIR_HORIZ = 2'd0,
    DIR_VERT  = 2'd1,
    DIR_DIAG  = 2'd2,
    DIR_ANTI  = 2'd3
  } dir_e;

  typedef struct packed {
    logic signed [1:0] drow;
    logic signed [1:0] dcol;
  } step_t;

  function automatic step_t dir_step(input logic [1:0] d);
    step_t s;
    case (d)
      DIR_HORIZ: s = '{2'sb00, 2'sb01};
      DIR_VERT:  s = '{2'sb01, 2'sb00};
      DIR_DIAG:  s = '{2'sb01, 2'sb01};
      default:   s = '{2'sb01, 2'sb11};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/gato_line_walker.sv
// Sequential win detector: from the placed cell, walks each direction's + side then - side,
// one neighbour per cycle, and reports done/win/dir once a run reaches WIN_LEN or all lines fail.
module gato_line_walker
  import gato_pkg::*;
#(
  parameter int N       = 3,
  parameter int WIN_LEN = 3,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [IDX_W-1:0] org_row,
  input  logic [IDX_W-1:0] org_col,
  input  logic [1:0]       player,
  input  logic [1:0]       board [N][N],
  output logic             done,
  output logic             win,
  output logic [1:0]       dir
);

  localparam int CW = IDX_W + 1;
  localparam int RW = $clog2(WIN_LEN + 1);

  logic          busy_q, done_q, win_q, side_q;
  logic [1:0]    dir_q, ply_q;
  logic [RW-1:0] step_q, run_q;
  logic [CW-1:0] cur_r_q, cur_c_q, org_r_q, org_c_q;

  step_t         st;
  logic [CW-1:0] dr_ext, dc_ext, nxt_r_d, nxt_c_d;
  logic [RW-1:0] run_d, step_d;
  logic          in_bnd, hit;

  // Coordinates carry one spare bit so stepping off either edge lands at >= N.
  always_comb begin
    st      = dir_step(dir_q);
    dr_ext  = {{(CW-2){st.drow[1]}}, st.drow};
    dc_ext  = {{(CW-2){st.dcol[1]}}, st.dcol};
    nxt_r_d = side_q ? cur_r_q - dr_ext : cur_r_q + dr_ext;
    nxt_c_d = side_q ? cur_c_q - dc_ext : cur_c_q + dc_ext;
    in_bnd  = (nxt_r_d < CW'(N)) && (nxt_c_d < CW'(N));
    hit     = 1'b0;
    if (in_bnd) hit = (board[nxt_r_d[IDX_W-1:0]][nxt_c_d[IDX_W-1:0]] == ply_q);
    run_d   = run_q + 1'b1;
    step_d  = step_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      win_q   <= 1'b0;
      side_q  <= 1'b0;
      dir_q   <= DIR_HORIZ;
      ply_q   <= CELL_EMPTY;
      step_q  <= '0;
      run_q   <= '0;
      cur_r_q <= '0;
      cur_c_q <= '0;
      org_r_q <= '0;
      org_c_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        busy_q <= 1'b0;
      end else if (start) begin
        busy_q  <= 1'b1;
        win_q   <= 1'b0;
        side_q  <= 1'b0;
        dir_q   <= DIR_HORIZ;
        ply_q   <= player;
        step_q  <= '0;
        run_q   <= RW'(1);
        cur_r_q <= {1'b0, org_row};
        cur_c_q <= {1'b0, org_col};
        org_r_q <= {1'b0, org_row};
        org_c_q <= {1'b0, org_col};
      end else if (busy_q) begin
        if (hit && run_d >= RW'(WIN_LEN)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          win_q  <= 1'b1;
        end else if (hit && step_d < RW'(WIN_LEN - 1)) begin
          cur_r_q <= nxt_r_d;
          cur_c_q <= nxt_c_d;
          run_q   <= run_d;
          step_q  <= step_d;
        end else begin
          cur_r_q <= org_r_q;
          cur_c_q <= org_c_q;
          step_q  <= '0;
          if (hit) run_q <= run_d;
          if (!side_q) begin
            side_q <= 1'b1;
          end else if (dir_q == DIR_ANTI) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            dir_q  <= dir_q + 2'd1;
            side_q <= 1'b0;
            run_q  <= RW'(1);
          end
        end
      end
    end
  end

  assign done = done_q;
  assign win  = win_q;
  assign dir  = dir_q;

endmodule

// File: rtl/gato_nxn_controller.sv
// N x N gato controller: board storage, turn FSM, move handshake and result flags.
// Optional per-turn forfeit timer is enabled by defining GATO_TURN_TIMEOUT_EN.
module gato_nxn_controller
  import gato_pkg::*;
#(
  parameter int N            = 3,
  parameter int WIN_LEN      = 3,
  parameter int TURN_TIMEOUT = 1000,
  localparam int IDX_W       = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset_all,
  input  logic             reset_game,
  input  logic             move_valid,
  input  logic [IDX_W-1:0] move_row,
  input  logic [IDX_W-1:0] move_col,
  output logic             move_ready,
  output logic             move_err,
  input  logic [IDX_W-1:0] rd_row,
  input  logic [IDX_W-1:0] rd_col,
  output logic [1:0]       rd_cell,
  output logic [2:0]       state,
  output logic             turno_p1,
  output logic             turno_p2,
  output logic             win_p1,
  output logic             win_p2,
  output logic             tie_game,
  output logic [1:0]       win_dir,
  output logic             timeout
);

  localparam int CW = IDX_W + 1;
  localparam int MW = $clog2(N * N + 1);

  state_e        state_q;
  logic [1:0]    board_q [N][N];
  logic [MW-1:0] moves_q;
  logic          mover_p2_q, move_err_q;
  logic [1:0]    rd_cell_q, win_dir_q;

  logic          in_turn, move_legal, walk_start, walk_done, walk_win, rd_in_range;
  logic [1:0]    player, walk_dir;

  always_comb begin
    in_turn     = (state_q == ST_P1_TURN) || (state_q == ST_P2_TURN);
    move_ready  = in_turn && !reset_game;
    player      = (state_q == ST_P2_TURN) ? CELL_P2 : CELL_P1;
    move_legal  = 1'b0;
    if (({1'b0, move_row} < CW'(N)) && ({1'b0, move_col} < CW'(N)))
      move_legal = (board_q[move_row][move_col] == CELL_EMPTY);
    walk_start  = move_valid && move_ready && move_legal;
    rd_in_range = ({1'b0, rd_row} < CW'(N)) && ({1'b0, rd_col} < CW'(N));
  end

  gato_line_walker #(.N(N), .WIN_LEN(WIN_LEN), .IDX_W(IDX_W)) u_walker (
    .clk    (clk),
    .rst    (reset_all),
    .clear  (reset_game),
    .start  (walk_start),
    .org_row(move_row),
    .org_col(move_col),
    .player (player),
    .board  (board_q),
    .done   (walk_done),
    .win    (walk_win),
    .dir    (walk_dir)
  );

`ifdef GATO_TURN_TIMEOUT_EN
  localparam int TW = $clog2(TURN_TIMEOUT);
  logic [TW-1:0] tmo_q;
  logic          timeout_q;
`endif

  always_ff @(posedge clk or posedge reset_all) begin
    if (reset_all) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) board_q[r][c] <= CELL_EMPTY;
      state_q    <= ST_P1_TURN;
      moves_q    <= '0;
      mover_p2_q <= 1'b0;
      move_err_q <= 1'b0;
      rd_cell_q  <= CELL_EMPTY;
      win_dir_q  <= DIR_HORIZ;
`ifdef GATO_TURN_TIMEOUT_EN
      tmo_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      // The read port sees the board as it stood before this edge.
      rd_cell_q  <= rd_in_range ? board_q[rd_row][rd_col] : CELL_EMPTY;
      move_err_q <= 1'b0;
`ifdef GATO_TURN_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      if (reset_game) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) board_q[r][c] <= CELL_EMPTY;
        state_q    <= ST_P1_TURN;
        moves_q    <= '0;
        mover_p2_q <= 1'b0;
        win_dir_q  <= DIR_HORIZ;
`ifdef GATO_TURN_TIMEOUT_EN
        tmo_q      <= '0;
`endif
      end else begin
        case (state_q)
          ST_P1_TURN, ST_P2_TURN: begin
            if (move_valid) begin
              if (move_legal) begin
                board_q[move_row][move_col] <= player;
                moves_q    <= moves_q + 1'b1;
                mover_p2_q <= (state_q == ST_P2_TURN);
                state_q    <= ST_CHECK;
              end else begin
                move_err_q <= 1'b1;
              end
`ifdef GATO_TURN_TIMEOUT_EN
              tmo_q <= '0;
`endif
            end
`ifdef GATO_TURN_TIMEOUT_EN
            else if (tmo_q == TW'(TURN_TIMEOUT - 2)) begin
              timeout_q <= 1'b1;
              tmo_q     <= '0;
              state_q   <= (state_q == ST_P1_TURN) ? ST_P2_TURN : ST_P1_TURN;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
`endif
          end
          ST_CHECK: begin
`ifdef GATO_TURN_TIMEOUT_EN
            tmo_q <= '0;
`endif
            if (walk_done) begin
              if (walk_win) begin
                state_q   <= mover_p2_q ? ST_WIN2 : ST_WIN1;
                win_dir_q <= walk_dir;
              end else if (moves_q == MW'(N * N)) begin
                state_q <= ST_TIE;
              end else begin
                state_q <= mover_p2_q ? ST_P1_TURN : ST_P2_TURN;
              end
            end
          end
          ST_WIN1, ST_WIN2, ST_TIE: state_q <= state_q;
          default:                  state_q <= ST_P1_TURN;
        endcase
      end
    end
  end

  assign move_err = move_err_q;
  assign rd_cell  = rd_cell_q;
  assign state    = state_q;
  assign turno_p1 = (state_q == ST_P1_TURN);
  assign turno_p2 = (state_q == ST_P2_TURN);
  assign win_p1   = (state_q == ST_WIN1);
  assign win_p2   = (state_q == ST_WIN2);
  assign tie_game = (state_q == ST_TIE);
  assign win_dir  = win_dir_q;
`ifdef GATO_TURN_TIMEOUT_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_gato_nxn_controller.sv
// Bench for gato_nxn_controller: a 3x3 and a 5x5/WIN_LEN=4 instance share stimulus; a game-rule
// model tracks the selected one every cycle, and directed scenarios pin key results with literals.
module tb_gato_nxn_controller;

  logic       clk = 1'b0;
  logic       reset_all, reset_game, move_valid, sel5;
  logic [2:0] move_row, move_col, rd_row, rd_col;

  logic       rdy3, err3, t13, t23, w13, w23, tie3, tmo3;
  logic [1:0] cell3, wd3;
  logic [2:0] st3;
  logic       rdy5, err5, t15, t25, w15, w25, tie5, tmo5;
  logic [1:0] cell5, wd5;
  logic [2:0] st5;

  always #5 clk = ~clk;

  gato_nxn_controller #(.N(3), .WIN_LEN(3)) u3 (
    .clk(clk), .reset_all(reset_all), .reset_game(reset_game), .move_valid(move_valid),
    .move_row(move_row[1:0]), .move_col(move_col[1:0]), .move_ready(rdy3), .move_err(err3),
    .rd_row(rd_row[1:0]), .rd_col(rd_col[1:0]), .rd_cell(cell3), .state(st3),
    .turno_p1(t13), .turno_p2(t23), .win_p1(w13), .win_p2(w23), .tie_game(tie3),
    .win_dir(wd3), .timeout(tmo3));

  gato_nxn_controller #(.N(5), .WIN_LEN(4), .TURN_TIMEOUT(16)) u5 (
    .clk(clk), .reset_all(reset_all), .reset_game(reset_game), .move_valid(move_valid),
    .move_row(move_row), .move_col(move_col), .move_ready(rdy5), .move_err(err5),
    .rd_row(rd_row), .rd_col(rd_col), .rd_cell(cell5), .state(st5),
    .turno_p1(t15), .turno_p2(t25), .win_p1(w15), .win_p2(w25), .tie_game(tie5),
    .win_dir(wd5), .timeout(tmo5));

  logic       o_rdy, o_err, o_t1, o_t2, o_w1, o_w2, o_tie, o_tmo;
  logic [1:0] o_cell, o_wd;
  logic [2:0] o_st;
  assign o_rdy  = sel5 ? rdy5  : rdy3;
  assign o_err  = sel5 ? err5  : err3;
  assign o_t1   = sel5 ? t15   : t13;
  assign o_t2   = sel5 ? t25   : t23;
  assign o_w1   = sel5 ? w15   : w13;
  assign o_w2   = sel5 ? w25   : w23;
  assign o_tie  = sel5 ? tie5  : tie3;
  assign o_tmo  = sel5 ? tmo5  : tmo3;
  assign o_cell = sel5 ? cell5 : cell3;
  assign o_wd   = sel5 ? wd5   : wd3;
  assign o_st   = sel5 ? st5   : st3;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- game-rule model ----------------
  int mN = 3, mW = 3, mTO = 1000;
  int mb [8][8];
  int mphase, mmoves, chk_left, out_state, out_dir, mwin_dir, mrd, mtcnt;
  bit merr, mtmo;

  task automatic model_reset();
    mN = sel5 ? 5 : 3;
    mW = sel5 ? 4 : 3;
    mTO = sel5 ? 16 : 1000;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mb[r][c] = 0;
    mphase = 0; mmoves = 0; chk_left = 0; mwin_dir = 0; mtcnt = 0;
  endtask

  // Walk order: dirs 0..3, + side then - side, each side at most WIN_LEN-1 looks.
  function automatic void outcome(input int r, input int c, input int p,
                                  output int visits, output bit won, output int wdir);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    visits = 0; won = 0; wdir = 0;
    for (int d = 0; d < 4 && !won; d++) begin
      int run;
      run = 1;
      for (int s = 0; s < 2 && !won; s++) begin
        int sg;
        sg = (s == 0) ? 1 : -1;
        for (int k = 1; k < mW; k++) begin
          int rr, cc;
          rr = r + sg * k * dr[d];
          cc = c + sg * k * dc[d];
          visits++;
          if (rr < 0 || rr >= mN || cc < 0 || cc >= mN) break;
          if (mb[rr][cc] != p) break;
          run++;
          if (run >= mW) begin won = 1; wdir = d; break; end
        end
      end
    end
  endfunction

  task automatic model_step();
    int r, c, p, vis, wd;
    bit won;
    merr = 0; mtmo = 0;
    if (reset_all) begin model_reset(); mrd = 0; return; end
    mrd = (int'(rd_row) < mN && int'(rd_col) < mN) ? mb[rd_row][rd_col] : 0;
    if (reset_game) begin model_reset(); return; end
    case (mphase)
      0, 1: begin
        p = mphase + 1;
        if (move_valid) begin
          r = int'(move_row); c = int'(move_col);
          mtcnt = 0;
          if (r < mN && c < mN && mb[r][c] == 0) begin
            mb[r][c] = p;
            mmoves++;
            outcome(r, c, p, vis, won, wd);
            chk_left = vis + 1;
            out_dir = wd;
            if (won) out_state = (p == 1) ? 3 : 4;
            else if (mmoves == mN * mN) out_state = 5;
            else out_state = (p == 1) ? 1 : 0;
            mphase = 2;
          end else merr = 1;
        end
`ifdef GATO_TURN_TIMEOUT_EN
        else if (mtcnt == mTO - 2) begin
          mtmo = 1; mtcnt = 0; mphase = (mphase == 0) ? 1 : 0;
        end else mtcnt++;
`endif
      end
      2: begin
        chk_left--;
        if (chk_left == 0) begin
          mphase = out_state;
          if (out_state == 3 || out_state == 4) mwin_dir = out_dir;
        end
      end
      default: ;
    endcase
  endtask

  // Compare process: model advances on the edge, outputs sampled 1 time unit later.
  initial begin
    model_reset();
    mrd = 0; merr = 0; mtmo = 0;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("state", o_st, mphase);
      chk("turno_p1", o_t1, mphase == 0);
      chk("turno_p2", o_t2, mphase == 1);
      chk("win_p1", o_w1, mphase == 3);
      chk("win_p2", o_w2, mphase == 4);
      chk("tie_game", o_tie, mphase == 5);
      chk("win_dir", o_wd, mwin_dir);
      chk("move_err", o_err, merr);
      chk("move_ready", o_rdy, (mphase <= 1) && !reset_game);
      chk("rd_cell", o_cell, mrd);
      chk("timeout", o_tmo, mtmo);
    end
  end

  // Display read-port scanner sweeps the active board continuously.
  initial begin
    rd_row = 0; rd_col = 0;
    forever begin
      @(negedge clk);
      if (int'(rd_col) + 1 >= mN) begin
        rd_col = 0;
        rd_row = (int'(rd_row) + 1 >= mN) ? 3'd0 : rd_row + 3'd1;
      end else rd_col = rd_col + 3'd1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic move(input int r, input int c);
    @(negedge clk);
    move_valid = 1'b1; move_row = 3'(r); move_col = 3'(c);
    @(negedge clk);
    move_valid = 1'b0;
  endtask

  task automatic new_game();
    @(negedge clk); reset_game = 1'b1;
    @(negedge clk); reset_game = 1'b0;
  endtask

  task automatic wait_code(input logic [2:0] code, input int bound, input string nm, output int n);
    n = 0;
    while (o_st !== code && n < bound) begin @(negedge clk); n++; end
    checks++;
    if (o_st !== code) begin
      errors++;
      $display("FAIL %s: state %0d after %0d cycles, required %0d", nm, o_st, n, code);
    end
  endtask

  task automatic wait_turn(input string nm);
    int n;
    n = 0;
    while (o_st > 3'd1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (o_st > 3'd1) begin
      errors++;
      $display("FAIL %s: state %0d, required a turn state within 40 cycles", nm, o_st);
    end
  endtask

  initial begin
    int cyc;
    reset_all = 1'b1; reset_game = 1'b0; move_valid = 1'b0;
    move_row = 0; move_col = 0; sel5 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", o_st, 0);
    chk("reset_turno_p1", o_t1, 1);
    reset_all = 1'b0;

    // 1: row-0 win for P1, plus a request during CHECK that must be ignored
    move(0, 0);
    move(2, 2);
    chk("t1_ignored_no_err", o_err, 0);
    wait_turn("t1_w1");
    move(1, 0); wait_turn("t1_w2");
    move(0, 1); wait_turn("t1_w3");
    move(1, 1); wait_turn("t1_w4");
    move(0, 2);
    wait_code(3'd3, 20, "t1_win", cyc);
    chk("t1_latency_le17", cyc <= 17, 1);
    chk("t1_win_p1", o_w1, 1);
    chk("t1_win_dir", o_wd, 0);

    // 2: illegal moves by P2
    new_game();
    move(0, 0); wait_turn("t2_w1");
    move(0, 0);
    chk("t2_err_occupied", o_err, 1);
    chk("t2_turno_p2_a", o_t2, 1);
    move(3, 0);
    chk("t2_err_row3", o_err, 1);
    chk("t2_turno_p2_b", o_t2, 1);
    @(negedge clk);
    chk("t2_err_drops", o_err, 0);

    // 3: tie game
    new_game();
    move(0, 0); wait_turn("t3"); move(0, 1); wait_turn("t3");
    move(0, 2); wait_turn("t3"); move(1, 1); wait_turn("t3");
    move(1, 0); wait_turn("t3"); move(2, 0); wait_turn("t3");
    move(2, 1); wait_turn("t3"); move(1, 2); wait_turn("t3");
    move(2, 2);
    wait_code(3'd5, 20, "t3_tie", cyc);
    chk("t3_tie_game", o_tie, 1);
    chk("t3_win_p1", o_w1, 0);
    chk("t3_win_p2", o_w2, 0);

    // 5: reset_game during CHECK with a simultaneous request
    new_game();
    move(1, 1);
    reset_game = 1'b1; move_valid = 1'b1; move_row = 0; move_col = 0;
    @(negedge clk);
    reset_game = 1'b0; move_valid = 1'b0;
    chk("t5_state", o_st, 0);
    chk("t5_turno_p1", o_t1, 1);
    repeat (12) @(negedge clk);

    // 4: 5x5, WIN_LEN=4, anti-diagonal by P2
    @(negedge clk); reset_all = 1'b1; sel5 = 1'b1;
    @(negedge clk); reset_all = 1'b0;
    move(0, 0); wait_turn("t4"); move(0, 3); wait_turn("t4");
    move(4, 4); wait_turn("t4"); move(1, 2); wait_turn("t4");
    move(4, 0); wait_turn("t4"); move(2, 1); wait_turn("t4");
    chk("t4_run3_no_win", o_w2, 0);
    chk("t4_run3_turno_p1", o_t1, 1);
    move(4, 2); wait_turn("t4");
    move(3, 0);
    wait_code(3'd4, 30, "t4_win", cyc);
    chk("t4_latency_le25", cyc <= 25, 1);
    chk("t4_win_p2", o_w2, 1);
    chk("t4_win_dir", o_wd, 3);

    // 6: turn timeout
    new_game();
`ifdef GATO_TURN_TIMEOUT_EN
    repeat (14) @(negedge clk);
    chk("t6_no_tmo_yet", o_tmo, 0);
    chk("t6_still_p1", o_t1, 1);
    @(negedge clk);
    chk("t6_timeout", o_tmo, 1);
    chk("t6_turno_p2", o_t2, 1);
    repeat (14) @(negedge clk);
    move_valid = 1'b1; move_row = 2; move_col = 2;
    @(negedge clk);
    move_valid = 1'b0;
    chk("t6_accept_on_expiry", o_st, 2);
    chk("t6_no_tmo_on_accept", o_tmo, 0);
`else
    repeat (40) @(negedge clk);
    chk("t6_waits_p1", o_t1, 1);
    chk("t6_no_timeout", o_tmo, 0);
`endif
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
